decode_stage: RTL
=================

# decode_stage

Buffered, parametrised instruction decode stage for the RISC-V pipeline. It accepts raw 32-bit instructions and their PCs from fetch over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It decodes the FIFO head into a registered control bundle for execute: register indices, sign-extended immediate, ALU op, datapath enables, branch code, one-hot type and illegal flag. It supports back-pressure from execute and a single-cycle pipeline flush on a taken branch or jump.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ALU_OP_W, 6, width of out_alu_op; at least 5.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents in_instr/in_pc.
- in_ready  out  1  FIFO not full.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction address.
- flush  in  1  discard all queued and output-held instructions.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  32  PC of bundle.
- out_rs1, out_rs2, out_rd  out  5 each  register fields.
- out_f3  out  3  funct3 passthrough (load/store size).
- out_imm  out  32  sign-extended immediate.
- out_alu_op  out  ALU_OP_W  ALU operation code.
- out_alusrc, out_memtoreg, out_mem_we, out_reg_we  out  1 each  datapath enables.
- out_branch  out  3  0 none; 1–6 BEQ, BNE, BLT, BGE, BLTU, BGEU; 7 JAL/JALR.
- out_type  out  9  one-hot: [8] R, [7] I-ALU, [6] load, [5] store, [4] branch, [3] JAL, [2] LUI, [1] AUIPC, [0] JALR; all zero for NOP.
- out_illegal  out  1  undecodable instruction.

## Operation
- Push: in_valid && in_ready writes {in_instr, in_pc} at the write pointer. in_ready = (count != DEPTH). There is no bypass when full.
- Pop: when the FIFO is non-empty and (!out_valid || out_ready), the head is decoded combinationally and the output register is loaded; out_valid is set.
- Drain: when out_ready is high and nothing pops in that cycle, out_valid clears.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop leaves count unchanged. Push and pop are legal at every non-full, non-empty count.
- Flush priority: reset > flush > push/pop.
  - flush clears pointers, count and out_valid at the next edge.
  - in_valid during the flush cycle is dropped.
  - in_ready stays combinational from count.
- Decode rules:
  - Opcode 0: NOP. All enables 0, type 0, alu_op 0, not illegal.
  - R-type ALU ops: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - I-type ALU ops: ADDI 10, XORI 11, ORI 12, ANDI 13, SLLI 14, SRLI 15, SRAI 16, SLTI 17, SLTIU 18.
  - AUIPC 19, LUI 20.
  - Loads and stores use alu_op 10 with alusrc 1.
  - Loads set memtoreg and reg_we. Stores set mem_we.
  - Branches set reg_we 0.
  - JAL and JALR set reg_we 1 and branch 7. JALR has alusrc 1.
  - Immediates follow the I/S/B/U/J formats, sign-extended from bit 31. R-type and NOP immediate is 0.
- Illegal: an unknown opcode, an undefined funct3/funct7 combination, or a JALR with funct3 != 0 sets out_illegal=1 with all enables 0, branch 0 and type 0.

## Timing
- Reset values: out_valid 0, all out_* fields 0, in_ready 1 (count 0), pointers 0.
- Latency: an instruction pushed at edge t into an empty FIFO with the output register free is popped at edge t+1. out_valid is high in the cycle after edge t+1, so the minimum latency is 2 cycles.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.
- The output bundle holds stable while out_valid && !out_ready.
- Reset or flush asserted mid-stream takes effect at the next edge. Nothing queued before that edge reaches the output afterwards.

## Configuration
- RV32M_EN defined:
  - Opcode 0110011 with funct7 0x01 decodes to MUL 21, MULH 22, MULHSU 23, MULHU 24, DIV 25, DIVU 26, REM 27, REMU 28.
  - These set type[8] and reg_we.
- RV32M_EN undefined: these encodings assert out_illegal.

## Test plan
- Reset, then push ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> 2 cycles later out_valid=1, alu_op 0, rs1 1, rs2 2, rd 3, reg_we 1, type 0x100.
- Push ADDI x5,x0,-1 (0xFFF00293) -> out_imm 0xFFFFFFFF, alu_op 10, alusrc 1.
- Hold out_ready=0 and push DEPTH+1 instructions -> in_ready drops after DEPTH+1 accepted (DEPTH in FIFO, 1 in output). Releasing out_ready drains them in order, one per cycle.
- Fill 3 entries, then assert flush with in_valid=1 -> next cycle out_valid 0, count 0. The flush-cycle instruction never appears.
- Push BGEU (0x0020F063), then an illegal opcode 0x0000007F -> branch 6 with type 0x010, then out_illegal 1 with all enables 0.
- Push MUL (0x022081B3) -> alu_op 21 with RV32M_EN; out_illegal 1 without it.

Source files
------------

// File: rtl/decode_stage.sv
// Buffered RV32 decode stage: DEPTH-entry fetch FIFO feeding a registered control bundle.
// Ports: fetch in_* handshake, flush, execute out_* handshake; RV32M_EN enables M-extension decode.
module decode_stage #(
  parameter int DEPTH    = 4,
  parameter int ALU_OP_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [31:0]         in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_f3,
  output logic [31:0]         out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_alusrc,
  output logic                out_memtoreg,
  output logic                out_mem_we,
  output logic                out_reg_we,
  output logic [2:0]          out_branch,
  output logic [8:0]          out_type,
  output logic                out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic push, pop;

  assign in_ready = (count != FULL);
  assign push = in_valid && in_ready;
  assign pop  = (count != '0) && (!out_valid || out_ready);

  logic [31:0] h;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  assign h   = mem_instr[rd_ptr];
  assign opc = h[6:0];
  assign f3  = h[14:12];
  assign f7  = h[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{h[31]}}, h[31:20]};
  assign imm_s = {{20{h[31]}}, h[31:25], h[11:7]};
  assign imm_b = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
  assign imm_u = {h[31:12], 12'b0};
  assign imm_j = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};

  logic [4:0]  op_n;
  logic [31:0] d_imm;
  logic        d_src, d_m2r, d_mwe, d_rwe, d_ill;
  logic [2:0]  d_br;
  logic [8:0]  d_typ;

  always_comb begin
    op_n  = '0;
    d_imm = '0;
    d_src = 1'b0;
    d_m2r = 1'b0;
    d_mwe = 1'b0;
    d_rwe = 1'b0;
    d_br  = 3'd0;
    d_typ = '0;
    d_ill = 1'b0;
    case (opc)
      7'b0000000: ;
      7'b0110011: begin
        d_typ = 9'h100;
        d_rwe = 1'b1;
        case (f7)
          7'h00: begin
            case (f3)
              3'd0: op_n = 5'd0;
              3'd1: op_n = 5'd5;
              3'd2: op_n = 5'd8;
              3'd3: op_n = 5'd9;
              3'd4: op_n = 5'd2;
              3'd5: op_n = 5'd6;
              3'd6: op_n = 5'd3;
              default: op_n = 5'd4;
            endcase
          end
          7'h20: begin
            if (f3 == 3'd0) op_n = 5'd1;
            else if (f3 == 3'd5) op_n = 5'd7;
            else d_ill = 1'b1;
          end
`ifdef RV32M_EN
          7'h01: op_n = 5'd21 + {2'b0, f3};
`endif
          default: d_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        d_typ = 9'h080;
        d_rwe = 1'b1;
        d_src = 1'b1;
        d_imm = imm_i;
        case (f3)
          3'd0: op_n = 5'd10;
          3'd1: begin
            op_n  = 5'd14;
            d_ill = (f7 != 7'h00);
          end
          3'd2: op_n = 5'd17;
          3'd3: op_n = 5'd18;
          3'd4: op_n = 5'd11;
          3'd5: begin
            if (f7 == 7'h00) op_n = 5'd15;
            else if (f7 == 7'h20) op_n = 5'd16;
            else d_ill = 1'b1;
          end
          3'd6: op_n = 5'd12;
          default: op_n = 5'd13;
        endcase
      end
      7'b0000011: begin
        d_typ = 9'h040;
        op_n  = 5'd10;
        d_src = 1'b1;
        d_m2r = 1'b1;
        d_rwe = 1'b1;
        d_imm = imm_i;
        d_ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0100011: begin
        d_typ = 9'h020;
        op_n  = 5'd10;
        d_src = 1'b1;
        d_mwe = 1'b1;
        d_imm = imm_s;
        d_ill = (f3 > 3'd2);
      end
      7'b1100011: begin
        d_typ = 9'h010;
        d_imm = imm_b;
        case (f3)
          3'd0: d_br = 3'd1;
          3'd1: d_br = 3'd2;
          3'd4: d_br = 3'd3;
          3'd5: d_br = 3'd4;
          3'd6: d_br = 3'd5;
          3'd7: d_br = 3'd6;
          default: d_ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        d_typ = 9'h008;
        d_rwe = 1'b1;
        d_br  = 3'd7;
        d_imm = imm_j;
      end
      7'b1100111: begin
        d_typ = 9'h001;
        op_n  = 5'd10;
        d_src = 1'b1;
        d_rwe = 1'b1;
        d_br  = 3'd7;
        d_imm = imm_i;
        d_ill = (f3 != 3'd0);
      end
      7'b0110111: begin
        d_typ = 9'h004;
        op_n  = 5'd20;
        d_src = 1'b1;
        d_rwe = 1'b1;
        d_imm = imm_u;
      end
      7'b0010111: begin
        d_typ = 9'h002;
        op_n  = 5'd19;
        d_src = 1'b1;
        d_rwe = 1'b1;
        d_imm = imm_u;
      end
      default: d_ill = 1'b1;
    endcase
    // an illegal instruction must not enable anything downstream
    if (d_ill) begin
      op_n  = '0;
      d_imm = '0;
      d_src = 1'b0;
      d_m2r = 1'b0;
      d_mwe = 1'b0;
      d_rwe = 1'b0;
      d_br  = 3'd0;
      d_typ = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_f3       <= '0;
      out_imm      <= '0;
      out_alu_op   <= '0;
      out_alusrc   <= 1'b0;
      out_memtoreg <= 1'b0;
      out_mem_we   <= 1'b0;
      out_reg_we   <= 1'b0;
      out_branch   <= '0;
      out_type     <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_pc       <= mem_pc[rd_ptr];
      out_rs1      <= h[19:15];
      out_rs2      <= h[24:20];
      out_rd       <= h[11:7];
      out_f3       <= f3;
      out_imm      <= d_imm;
      out_alu_op   <= ALU_OP_W'(op_n);
      out_alusrc   <= d_src;
      out_memtoreg <= d_m2r;
      out_mem_we   <= d_mwe;
      out_reg_we   <= d_rwe;
      out_branch   <= d_br;
      out_type     <= d_typ;
      out_illegal  <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
